// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// astra_bus_pkg : shared bus constants and owner encoding for mem_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package astra_bus_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int DW_DEFAULT = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if : core, DMA and RAM buses around the RAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cpu_rw;
  logic [AW-1:0] cpu_ad;
  logic [DW-1:0] cpu_d_out;
  logic [DW-1:0] cpu_d_in;
  logic          cpu_rdy;

  logic          dma_req;
  logic          dma_rw;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          mem_rw;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d_out;
  logic [DW-1:0] mem_d_in;

  // Arbiter side
  modport slave (
    input  cpu_rw, cpu_ad, cpu_d_out, dma_req, dma_rw, dma_addr, dma_wdata, mem_d_in,
    output cpu_d_in, cpu_rdy, dma_ack, dma_rvalid, dma_rdata, mem_rw, mem_a, mem_d_out
  );

  // Requesters and RAM side
  modport master (
    output cpu_rw, cpu_ad, cpu_d_out, dma_req, dma_rw, dma_addr, dma_wdata, mem_d_in,
    input  cpu_d_in, cpu_rdy, dma_ack, dma_rvalid, dma_rdata, mem_rw, mem_a, mem_d_out
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_burst_guard.sv
// ---------------------------------------------------------------------------
// burst_guard : counts consecutive DMA acks and forces one CPU cycle at MAX_BURST
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module burst_guard #(
  parameter int MAX_BURST = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic own_i,
  input  wire logic ack_i,
  output logic      force_release_o
);
  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] burst_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else if (!own_i) begin
      burst_cnt_q <= '0;
    end else if (ack_i && (burst_cnt_q != C_LAST)) begin
      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end

  assign force_release_o = own_i & ack_i & (burst_cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : shares the single-port RAM between the 6502 core and a DMA port.
// Optional starvation guard enabled by macro ARB_STARVE_GUARD_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import astra_bus_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 16
) (
  input wire logic     clk,
  input wire logic     rst,
  mem_arbiter_if.slave bus
);

  if (MAX_BURST < 2) begin : g_bad_max_burst
    $error("mem_arbiter: MAX_BURST must be at least 2");
  end

  owner_t        own_q, own_d;
  logic          prev_cpu_q;
  logic [DW-1:0] cpu_hold_q;
  logic          dma_rvalid_q;

  logic          w_dma_ack;
  logic          w_force_release;
  logic [AW-1:0] w_mem_a;

  assign w_dma_ack = (own_q == OWN_DMA) & bus.dma_req;

`ifdef ARB_STARVE_GUARD_EN
  burst_guard #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_guard (
    .clk            (clk),
    .rst            (rst),
    .own_i          (own_q == OWN_DMA),
    .ack_i          (w_dma_ack),
    .force_release_o(w_force_release)
  );
`else
  assign w_force_release = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q <= OWN_CPU;
    end else begin
      own_q <= own_d;
    end
  end

  always_comb begin
    own_d         = OWN_CPU;
    bus.mem_rw    = bus.cpu_rw;
    w_mem_a       = bus.cpu_ad;
    bus.mem_d_out = bus.cpu_d_out;
    if (own_q == OWN_CPU) begin
      if (bus.dma_req) begin
        own_d = OWN_DMA;
      end
    end else begin
      // A dropped request turns the owned cycle into a harmless idle read
      bus.mem_rw    = bus.dma_req ? bus.dma_rw : RW_READ;
      w_mem_a       = bus.dma_addr;
      bus.mem_d_out = bus.dma_wdata;
      if (bus.dma_req && !w_force_release) begin
        own_d = OWN_DMA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cpu_q   <= 1'b1;
      cpu_hold_q   <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      prev_cpu_q   <= (own_q == OWN_CPU);
      if (prev_cpu_q) begin
        cpu_hold_q <= bus.mem_d_in;
      end
      dma_rvalid_q <= w_dma_ack & (bus.dma_rw == RW_READ);
    end
  end

  assign bus.mem_a      = w_mem_a;
  assign bus.cpu_rdy    = (own_q == OWN_CPU);
  assign bus.dma_ack    = w_dma_ack;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = bus.mem_d_in;
  // The core keeps seeing its last read while the DMA port owns the RAM
  assign bus.cpu_d_in   = prev_cpu_q ? bus.mem_d_in : cpu_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed vector bench for mem_arbiter with a 1-cycle RAM model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] ram [0:65535];

  mem_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_arbiter #(.AW(16), .DW(8), .MAX_BURST(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rw == 1'b0) ram[bus.mem_a] <= bus.mem_d_out;
    bus.mem_d_in <= ram[bus.mem_a];
  end

  typedef struct {
    logic        cpu_rw;
    logic [15:0] cpu_ad;
    logic [7:0]  cpu_do;
    logic        req;
    logic        drw;
    logic [15:0] da;
    logic [7:0]  dwd;
    logic        e_rdy;
    logic        e_ack;
    logic        e_rv;
    logic        e_mrw;
    logic [15:0] e_ma;
    logic [7:0]  e_mdo;
    logic [7:0]  e_din;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic crw, logic [15:0] cad, logic [7:0] cdo,
                              logic rq, logic drw, logic [15:0] da, logic [7:0] dwd,
                              logic rdy, logic ack, logic rv, logic mrw,
                              logic [15:0] ma, logic [7:0] mdo, logic [7:0] din,
                              logic [7:0] rdata);
    vec_t v;
    v.cpu_rw = crw; v.cpu_ad = cad; v.cpu_do = cdo;
    v.req = rq; v.drw = drw; v.da = da; v.dwd = dwd;
    v.e_rdy = rdy; v.e_ack = ack; v.e_rv = rv; v.e_mrw = mrw;
    v.e_ma = ma; v.e_mdo = mdo; v.e_din = din; v.e_rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks;
    logic exp_ack;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[0] = 8'hEA; ram[1] = 8'hA9; ram[2] = 8'h55; ram[3] = 8'h69;
    ram[4] = 8'h03; ram[5] = 8'h29; ram[6] = 8'hF0; ram[7] = 8'hEA;

    //            crw cad       cdo    rq   drw  da        dwd    rdy  ack  rv   mrw  ma        mdo    din    rdata
    vecs[0]  = mk(1, 16'h0000, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0000, 8'h00, 8'hEA, 8'h00);
    vecs[1]  = mk(1, 16'h0001, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0001, 8'h00, 8'hEA, 8'h00);
    vecs[2]  = mk(1, 16'h0002, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0002, 8'h00, 8'hA9, 8'h00);
    vecs[3]  = mk(0, 16'h0010, 8'h77, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 0, 16'h0010, 8'h77, 8'h55, 8'h00);
    vecs[4]  = mk(1, 16'h0010, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0010, 8'h00, 8'h00, 8'h00);
    vecs[5]  = mk(1, 16'h0003, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0003, 8'h00, 8'h77, 8'h00);
    vecs[6]  = mk(1, 16'h0001, 8'h00, 1, 0, 16'h0200, 8'hA5, 1, 0, 0, 1, 16'h0001, 8'h00, 8'h69, 8'h00);
    vecs[7]  = mk(1, 16'h0001, 8'h00, 1, 0, 16'h0200, 8'hA5, 0, 1, 0, 0, 16'h0200, 8'hA5, 8'hA9, 8'h00);
    vecs[8]  = mk(1, 16'h0001, 8'h00, 0, 0, 16'h0200, 8'hA5, 0, 0, 0, 1, 16'h0200, 8'hA5, 8'hA9, 8'h00);
    vecs[9]  = mk(1, 16'h0001, 8'h00, 0, 1, 16'h0200, 8'h00, 1, 0, 0, 1, 16'h0001, 8'h00, 8'hA9, 8'h00);
    vecs[10] = mk(1, 16'h0001, 8'h00, 1, 1, 16'h0200, 8'h00, 1, 0, 0, 1, 16'h0001, 8'h00, 8'hA9, 8'h00);
    vecs[11] = mk(1, 16'h0001, 8'h00, 1, 1, 16'h0200, 8'h00, 0, 1, 0, 1, 16'h0200, 8'h00, 8'hA9, 8'h00);
    vecs[12] = mk(0, 16'h0001, 8'hFF, 1, 1, 16'h0010, 8'h00, 0, 1, 1, 1, 16'h0010, 8'h00, 8'hA9, 8'hA5);
    vecs[13] = mk(0, 16'h0001, 8'hFF, 1, 1, 16'h0000, 8'h00, 0, 1, 1, 1, 16'h0000, 8'h00, 8'hA9, 8'h77);
    vecs[14] = mk(1, 16'h0001, 8'h00, 0, 1, 16'h0000, 8'h00, 0, 0, 1, 1, 16'h0000, 8'h00, 8'hA9, 8'hEA);
    vecs[15] = mk(1, 16'h0001, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0001, 8'h00, 8'hA9, 8'h00);
    vecs[16] = mk(1, 16'h0001, 8'h00, 0, 1, 16'h0000, 8'h00, 1, 0, 0, 1, 16'h0001, 8'h00, 8'hA9, 8'h00);

    rst = 1'b1;
    bus.cpu_rw = 1'b1; bus.cpu_ad = 16'h0000; bus.cpu_d_out = 8'h00;
    bus.dma_req = 1'b0; bus.dma_rw = 1'b1; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_rdy", bus.cpu_rdy, 1'b1);
    chk("reset_ack", bus.dma_ack, 1'b0);
    chk("reset_rvalid", bus.dma_rvalid, 1'b0);
    chk("reset_mem_a", bus.mem_a, 16'h0000);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.cpu_rw = vecs[i].cpu_rw; bus.cpu_ad = vecs[i].cpu_ad; bus.cpu_d_out = vecs[i].cpu_do;
      bus.dma_req = vecs[i].req; bus.dma_rw = vecs[i].drw;
      bus.dma_addr = vecs[i].da; bus.dma_wdata = vecs[i].dwd;
      #4;
      chk($sformatf("v%0d_rdy", i), bus.cpu_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_ack", i), bus.dma_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_rvalid", i), bus.dma_rvalid, vecs[i].e_rv);
      chk($sformatf("v%0d_mem_rw", i), bus.mem_rw, vecs[i].e_mrw);
      chk($sformatf("v%0d_mem_a", i), bus.mem_a, vecs[i].e_ma);
      chk($sformatf("v%0d_mem_d_out", i), bus.mem_d_out, vecs[i].e_mdo);
      chk($sformatf("v%0d_cpu_d_in", i), bus.cpu_d_in, vecs[i].e_din);
      if (vecs[i].e_rv) chk($sformatf("v%0d_rdata", i), bus.dma_rdata, vecs[i].e_rdata);
      next_cycle();
    end

    // Long DMA write request to exercise the starvation guard (or its absence)
    acks = 0;
    bus.dma_req = 1'b1; bus.dma_rw = 1'b0; bus.dma_addr = 16'h0300;
    for (int c = 0; c <= 40; c++) begin
      bus.dma_wdata = 8'(c);
`ifdef ARB_STARVE_GUARD_EN
      exp_ack = (c >= 1) && (((c - 1) % 17) < 16);
`else
      exp_ack = (c >= 1);
`endif
      #4;
      chk($sformatf("burst%0d_ack", c), bus.dma_ack, exp_ack);
      chk($sformatf("burst%0d_rdy", c), bus.cpu_rdy, !exp_ack);
      if (bus.dma_ack === 1'b1) acks++;
      next_cycle();
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("burst_total_acks", acks, 38);
`else
    chk("burst_total_acks", acks, 40);
`endif
    bus.dma_req = 1'b0;
    next_cycle();
    next_cycle();

    // Asynchronous reset in the middle of a DMA read burst
    bus.cpu_ad = 16'h0005; bus.cpu_rw = 1'b1;
    bus.dma_req = 1'b1; bus.dma_rw = 1'b1; bus.dma_addr = 16'h0200;
    next_cycle();
    next_cycle();
    #4;
    chk("pre_reset_ack", bus.dma_ack, 1'b1);
    chk("pre_reset_rvalid", bus.dma_rvalid, 1'b1);
    #1;
    rst = 1'b1;
    bus.cpu_ad = 16'h0000;
    #1;
    chk("async_rst_rdy", bus.cpu_rdy, 1'b1);
    chk("async_rst_ack", bus.dma_ack, 1'b0);
    chk("async_rst_rvalid", bus.dma_rvalid, 1'b0);
    chk("async_rst_mem_a", bus.mem_a, 16'h0000);
    bus.dma_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    #4;
    chk("post_rst_rdy", bus.cpu_rdy, 1'b1);
    chk("post_rst_fetch0", bus.cpu_d_in, 8'hEA);
    next_cycle();
    bus.cpu_ad = 16'h0001;
    next_cycle();
    #4;
    chk("post_rst_fetch1", bus.cpu_d_in, 8'hA9);
    chk("post_rst_ack", bus.dma_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
